// File: rtl/drive_cmd_arbiter.sv
// drive_cmd_arbiter: sole driver of the car command bus.
// Mode-selected source, stop guard on mode change, barrier pulses.
module drive_cmd_arbiter #(
  parameter int TICK_DIV    = 2000000,
  parameter int GUARD_TICKS = 25,
  parameter int PULSE_TICKS = 5
) (
  input  logic       clk,
  input  logic       power,
  input  logic [1:0] mode,
  input  logic [7:0] man_cmd,
  input  logic [7:0] semi_cmd,
  input  logic [7:0] auto_cmd,
  output logic [7:0] out,
  output logic [1:0] active_src,
  output logic       guard_busy
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW = (GUARD_TICKS > 1) ? $clog2(GUARD_TICKS) : 1;
  localparam int PW = (PULSE_TICKS > 1) ? $clog2(PULSE_TICKS) : 1;

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_TICKS - 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GUARD = 2'b01,
    RUN   = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q;
  logic [GW-1:0] guard_q, guard_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [1:0]    mode_q;
  logic [1:0]    edge_q, edge_d;
  logic [7:0]    out_q, out_d;

  logic       tick;
  logic       mode_chg;
  logic [7:0] sel;
  logic [3:0] dir;
  logic [1:0] rise;
  logic       pls_on;

  assign tick     = (tick_q == TICK_LAST);
  assign mode_chg = (mode != mode_q);
  assign rise     = sel[5:4] & ~edge_q;
  assign pls_on   = |out_q[5:4];

  // Free-running tick divider, cleared only by power.
  always_ff @(posedge clk or negedge power) begin
    if (!power) tick_q <= '0;
    else if (tick) tick_q <= '0;
    else tick_q <= tick_q + TW'(1);
  end

  // Source select by live mode; unknown/off selects nothing.
  always_comb begin
    sel = 8'h00;
    unique case (mode)
      2'b01:   sel = man_cmd;
      2'b10:   sel = semi_cmd;
      2'b11:   sel = auto_cmd;
      default: sel = 8'h00;
    endcase
  end

  // Drop contradictory direction pairs.
  always_comb begin
    dir = sel[3:0];
    if (sel[0] & sel[1]) dir[1:0] = 2'b00;
    if (sel[2] & sel[3]) dir[3:2] = 2'b00;
  end

  // Next state, guard/pulse counters and next bus value.
  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    pcnt_d  = pcnt_q;
    edge_d  = edge_q;
    out_d   = 8'h00;
    unique case (state_q)
      IDLE: begin
        if (mode != 2'b00) begin
          state_d = GUARD;
          guard_d = '0;
        end
      end
      GUARD: begin
        if (mode == 2'b00) begin
          state_d = IDLE;
          guard_d = '0;
        end else if (mode_chg) begin
          guard_d = '0;
        end else if (tick) begin
          if (guard_q == GUARD_LAST) begin
            state_d = RUN;
            guard_d = '0;
            edge_d  = sel[5:4];
          end else begin
            guard_d = guard_q + GW'(1);
          end
        end
      end
      RUN: begin
        if (mode == 2'b00 || mode_chg) begin
          state_d = (mode == 2'b00) ? IDLE : GUARD;
          guard_d = '0;
          pcnt_d  = '0;
        end else begin
          edge_d     = sel[5:4];
          out_d[3:0] = dir;
          if (pls_on) begin
            out_d[5:4] = out_q[5:4];
            if (tick) begin
              if (pcnt_q == PULSE_LAST) begin
                out_d[5:4] = 2'b00;
                pcnt_d     = '0;
              end else begin
                pcnt_d = pcnt_q + PW'(1);
              end
            end
          end else if (rise[1]) begin
            out_d[5] = 1'b1;
            pcnt_d   = '0;
          end else if (rise[0]) begin
            out_d[4] = 1'b1;
            pcnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters, mode/edge history and registered bus.
  always_ff @(posedge clk or negedge power) begin
    if (!power) begin
      state_q <= IDLE;
      guard_q <= '0;
      pcnt_q  <= '0;
      mode_q  <= 2'b00;
      edge_q  <= 2'b00;
      out_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      guard_q <= guard_d;
      pcnt_q  <= pcnt_d;
      mode_q  <= mode;
      edge_q  <= edge_d;
      out_q   <= out_d;
    end
  end

  assign out        = out_q;
  assign active_src = (state_q == RUN) ? mode_q : 2'b00;
  assign guard_busy = (state_q == GUARD);

endmodule
